mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master, one-slave arbiter for the physical memory bus. It shares the single physical port between an instruction-side requester (m0) and a data-side requester (m1), typically each an MMU's physical output. It uses round-robin priority and one transaction at a time. A per-transaction timeout aborts hung accesses and reports them as a bus error.

## Interface
Parameters:
- TIMEOUT, default 255: number of cycles in a bus state with no ack_i before the arbiter aborts; legal range 1..255.
- CNT_W, default 8: width of the timeout counter; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  clock; every register updates on the posedge.
- rst  in  1  reset, synchronous, active-high.
- m0_addr_i  in  32  master 0 address.
- m0_data_i  in  32  master 0 write data.
- m0_data_o  out  32  read data to master 0.
- m0_we_i  in  1  master 0 write request.
- m0_rd_i  in  1  master 0 read request.
- m0_ack_o  out  1  completion pulse to master 0.
- m1_addr_i, m1_data_i, m1_data_o, m1_we_i, m1_rd_i, m1_ack_o: same as the m0 ports, for master 1.
- addr_o  out  32  slave address.
- data_o  out  32  slave write data.
- we_o  out  1  slave write strobe.
- rd_o  out  1  slave read strobe.
- data_i  in  32  slave read data.
- ack_i  in  1  slave completion, one-cycle pulse.
- grant  out  2  one-hot owner: bit0 = m0, bit1 = m1, 00 = idle.
- bus_err  out  1  registered one-cycle pulse on a timeout.
- bus_err_addr  out  32  address of the last timed-out access; holds its value until the next error.

## Operation
- A master requests by asserting rd_i or we_i. It holds addr, data, rd and we stable until its ack_o.
- States:
  - IDLE. No transaction in progress.
  - BUS0. The bus is granted to m0.
  - BUS1. The bus is granted to m1.
- IDLE transitions, decided on the registered last_grant:
  - Only m0 requests: go to BUS0.
  - Only m1 requests: go to BUS1.
  - Both request: grant the master that is not last_grant.
  - Neither requests: stay in IDLE.
  - ack_i is ignored in IDLE.
- While in BUSn:
  - addr_o, data_o, we_o and rd_o follow master n combinationally.
  - mn_ack_o = ack_i; mn_data_o = data_i.
  - The other master sees ack 0 and data 0.
  - grant = onehot(n).
- In IDLE, addr_o, data_o, we_o, rd_o and grant are all 0.
- Leaving BUSn:
  - ack_i = 1: go to IDLE and set last_grant = n.
  - Master n deasserts both rd and we without an ack (abort): go to IDLE. last_grant is unchanged and no error is raised.
- Timeout:
  - cnt clears on entry to BUSn and increments each cycle spent in BUSn.
  - The timeout fires in the cycle where cnt == TIMEOUT and ack_i == 0. In that cycle the arbiter:
    - forces we_o = rd_o = 0;
    - drives mn_ack_o = 1 and mn_data_o = 32'hFFFFFFFF;
    - moves to IDLE next, with last_grant = n.
  - On the next cycle, bus_err = 1 and bus_err_addr = the address master n held.
  - If ack_i = 1 in the timeout cycle, the ack wins: normal completion, no error.
- Every completed transaction is followed by exactly one IDLE cycle. The master uses that cycle to drop or change its request, so back-to-back requests from the same master are not double-acked.

## Timing
- Reset values: state = IDLE, last_grant = m1 (so m0 wins the first tie), cnt = 0, grant = 00, bus_err = 0, bus_err_addr = 0. All slave-side outputs and both ack_o are 0.
- Grant latency: a request seen in IDLE at cycle t gives grant and slave strobes at cycle t+1.
- mn_ack_o has zero latency from ack_i; the arbiter is in IDLE at the cycle after the ack.
- Minimum transaction: 1 IDLE cycle + 1 bus cycle when ack_i arrives in the first bus cycle.
- Timeout abort occurs in the (TIMEOUT+1)th bus cycle. bus_err is asserted one cycle later.
- rst asserted mid-transaction: the next cycle is IDLE with all outputs at reset values. No ack and no bus_err are generated.
- A simultaneous abort and ack_i in the same cycle is treated as a normal completion.

## Test plan
- m0 read of 0x1000; slave acks in bus cycle 1 with data_i = 0xDEADBEEF → grant = 01 from cycle 1; m0_ack_o = 1 with m0_data_o = 0xDEADBEEF in cycle 1; m1 sees ack 0.
- Both masters request continuously, slave acks each grant after 2 cycles → grant sequence 01, 00, 10, 00, 01… with m0 first; no master is granted twice in a row.
- m1 write of 0x20 to 0x2004 with no ack, TIMEOUT = 4 → we_o high for 4 cycles, dropped in cycle 5 with m1_ack_o = 1 and m1_data_o = 0xFFFFFFFF; bus_err pulse in cycle 6 with bus_err_addr = 0x2004.
- TIMEOUT = 4, ack_i first asserted in the timeout cycle → normal completion, bus_err stays 0.
- m0 granted, then m0_rd_i drops before any ack → IDLE next cycle, no ack, no error; a pending m1 request is granted on the following IDLE decision.
- rst pulsed during BUS1 → grant = 00 and rd_o = 0 next cycle; the next tie goes to m0.

Source files
------------

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-master / one-slave memory bus arbiter. Round-robin priority,
//            one transaction at a time, per-transaction timeout that aborts
//            a hung access and reports it as a bus error.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    // master 0 (instruction side)
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    output logic [31:0] m0_data_o,
    input  logic        m0_we_i,
    input  logic        m0_rd_i,
    output logic        m0_ack_o,
    // master 1 (data side)
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    output logic [31:0] m1_data_o,
    input  logic        m1_we_i,
    input  logic        m1_rd_i,
    output logic        m1_ack_o,
    // slave port
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    output logic        we_o,
    output logic        rd_o,
    input  logic [31:0] data_i,
    input  logic        ack_i,
    // status
    output logic [1:0]  grant,
    output logic        bus_err,
    output logic [31:0] bus_err_addr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS0 = 2'd1,
        BUS1 = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               last_grant;      // 0 = m0 served last, 1 = m1
    logic               last_grant_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               timeout;

    logic               req0;
    logic               req1;
    logic               sel;             // owner index while on the bus
    logic [31:0]        own_addr;
    logic [31:0]        own_data;
    logic               own_we;
    logic               own_rd;
    logic               own_req;
    logic               own_ack;
    logic [31:0]        own_rdata;

    assign req0      = m0_rd_i | m0_we_i;
    assign req1      = m1_rd_i | m1_we_i;
    assign sel       = (state == BUS1);
    assign own_addr  = sel ? m1_addr_i : m0_addr_i;
    assign own_data  = sel ? m1_data_i : m0_data_i;
    assign own_we    = sel ? m1_we_i   : m0_we_i;
    assign own_rd    = sel ? m1_rd_i   : m0_rd_i;
    assign own_req   = own_we | own_rd;

    // Next-state decision and bus steering; ack beats abort beats timeout.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        timeout        = 1'b0;
        addr_o         = 32'h0;
        data_o         = 32'h0;
        we_o           = 1'b0;
        rd_o           = 1'b0;
        grant          = 2'b00;
        own_ack        = 1'b0;
        own_rdata      = 32'h0;
        case (state)
            IDLE: begin
                if (req0 && (!req1 || last_grant)) begin
                    state_nxt = BUS0;
                end else if (req1) begin
                    state_nxt = BUS1;
                end
            end
            BUS0, BUS1: begin
                addr_o    = own_addr;
                data_o    = own_data;
                we_o      = own_we;
                rd_o      = own_rd;
                grant     = sel ? 2'b10 : 2'b01;
                own_ack   = ack_i;
                own_rdata = data_i;
                if (ack_i) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = sel;
                end else if (!own_req) begin
                    state_nxt      = IDLE;
                end else if (cnt == CNT_W'(TIMEOUT)) begin
                    timeout        = 1'b1;
                    we_o           = 1'b0;
                    rd_o           = 1'b0;
                    own_ack        = 1'b1;
                    own_rdata      = 32'hFFFF_FFFF;
                    state_nxt      = IDLE;
                    last_grant_nxt = sel;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Route completion and read data only to the current owner.
    always_comb begin
        m0_ack_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m0_data_o = 32'h0;
        m1_data_o = 32'h0;
        if (state == BUS0) begin
            m0_ack_o  = own_ack;
            m0_data_o = own_rdata;
        end else if (state == BUS1) begin
            m1_ack_o  = own_ack;
            m1_data_o = own_rdata;
        end
    end

    // State, priority memory and bus-cycle counter; cnt is 0 in the first bus cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            if (state != IDLE && state_nxt != IDLE) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

    // Error pulse one cycle after a timeout, address held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err      <= 1'b0;
            bus_err_addr <= 32'h0;
        end else begin
            bus_err <= timeout;
            if (timeout) begin
                bus_err_addr <= own_addr;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter: directed scenarios with
//            literal expectations plus randomized masters/slave checked every
//            cycle against a transaction-level model of the arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] maddr [2];
    logic [31:0] mdata [2];
    logic        mwe   [2];
    logic        mrd   [2];
    logic [31:0] m0_data_o, m1_data_o;
    logic        m0_ack_o, m1_ack_o;
    logic [31:0] addr_o, data_o, data_i;
    logic        we_o, rd_o, ack_i;
    logic [1:0]  grant;
    logic        bus_err;
    logic [31:0] bus_err_addr;

    int n_chk  = 0;
    int n_fail = 0;

    // model: owner 0 = none, 1 = m0, 2 = m1; cyc = bus cycles already spent
    int          owner = 0;
    bit          last  = 1'b1;
    int          cyc   = 0;
    bit          errp  = 1'b0;
    logic [31:0] erra  = 32'h0;
    bit          seen_ack [2];

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .m0_addr_i(maddr[0]), .m0_data_i(mdata[0]), .m0_data_o(m0_data_o),
        .m0_we_i(mwe[0]), .m0_rd_i(mrd[0]), .m0_ack_o(m0_ack_o),
        .m1_addr_i(maddr[1]), .m1_data_i(mdata[1]), .m1_data_o(m1_data_o),
        .m1_we_i(mwe[1]), .m1_rd_i(mrd[1]), .m1_ack_o(m1_ack_o),
        .addr_o(addr_o), .data_o(data_o), .we_o(we_o), .rd_o(rd_o),
        .data_i(data_i), .ack_i(ack_i),
        .grant(grant), .bus_err(bus_err), .bus_err_addr(bus_err_addr)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic new_req(input int m);
        maddr[m] = $urandom;
        mdata[m] = $urandom;
        if ($urandom_range(0, 1) == 1) begin
            mrd[m] = 1'b1; mwe[m] = 1'b0;
        end else begin
            mrd[m] = 1'b0; mwe[m] = 1'b1;
        end
    endtask

    // Per-cycle compare against the model, then advance the model.
    initial begin : compare
        int          o;
        bit          req, tmo, r0, r1;
        logic [31:0] e_addr, e_data, e_rdat;
        logic        e_we, e_rd, e_ack;
        logic [1:0]  e_grant;
        @(posedge clk);
        forever begin
            @(negedge clk);
            o   = owner - 1;
            r0  = mrd[0] | mwe[0];
            r1  = mrd[1] | mwe[1];
            req = (owner != 0) && (mrd[o] | mwe[o]);
            tmo = (owner != 0) && !ack_i && req && (cyc == TMO);
            e_addr = 32'h0; e_data = 32'h0; e_we = 1'b0; e_rd = 1'b0;
            e_ack = 1'b0; e_rdat = 32'h0; e_grant = 2'b00;
            if (owner != 0) begin
                e_addr  = maddr[o];
                e_data  = mdata[o];
                e_we    = tmo ? 1'b0 : mwe[o];
                e_rd    = tmo ? 1'b0 : mrd[o];
                e_ack   = ack_i | tmo;
                e_rdat  = tmo ? 32'hFFFF_FFFF : data_i;
                e_grant = (owner == 1) ? 2'b01 : 2'b10;
            end
            chk("grant", 32'(grant), 32'(e_grant));
            chk("addr_o", addr_o, e_addr);
            chk("data_o", data_o, e_data);
            chk("we_o", 32'(we_o), 32'(e_we));
            chk("rd_o", 32'(rd_o), 32'(e_rd));
            chk("m0_ack", 32'(m0_ack_o), 32'(owner == 1 && e_ack));
            chk("m1_ack", 32'(m1_ack_o), 32'(owner == 2 && e_ack));
            chk("m0_data", m0_data_o, (owner == 1) ? e_rdat : 32'h0);
            chk("m1_data", m1_data_o, (owner == 2) ? e_rdat : 32'h0);
            chk("bus_err", 32'(bus_err), 32'(errp));
            chk("bus_err_addr", bus_err_addr, erra);
            seen_ack[0] = (owner == 1) && e_ack;
            seen_ack[1] = (owner == 2) && e_ack;
            if (rst) begin
                owner = 0; last = 1'b1; cyc = 0; errp = 1'b0; erra = 32'h0;
            end else begin
                errp = tmo;
                if (tmo) erra = maddr[o];
                if (owner == 0) begin
                    cyc = 0;
                    if (r0 && (!r1 || last)) owner = 1;
                    else if (r1)             owner = 2;
                end else if (ack_i || tmo) begin
                    last  = (owner == 2);
                    owner = 0;
                end else if (!req) begin
                    owner = 0;
                end else begin
                    cyc++;
                end
            end
        end
    end

    // Stimulus: directed scenarios with literal expectations, then random traffic.
    initial begin : stim
        logic [1:0] rr_exp [12];
        rr_exp = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10,
                   2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
        for (int m = 0; m < 2; m++) begin
            maddr[m] = 32'h0; mdata[m] = 32'h0; mwe[m] = 1'b0; mrd[m] = 1'b0;
        end
        ack_i = 1'b0; data_i = 32'h0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        chk("rst_err_addr", bus_err_addr, 32'h0);
        chk("rst_acks", 32'({m1_ack_o, m0_ack_o}), 32'h0);
        chk("rst_strobes", 32'({we_o, rd_o}), 32'h0);

        // m0 read of 0x1000, acked in the first bus cycle
        step(); mrd[0] = 1'b1; maddr[0] = 32'h1000;
        @(negedge clk); chk("t1_idle_grant", 32'(grant), 32'h0);
        step(); ack_i = 1'b1; data_i = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_addr", addr_o, 32'h1000);
        chk("t1_m0_ack", 32'(m0_ack_o), 32'h1);
        chk("t1_m0_data", m0_data_o, 32'hDEAD_BEEF);
        chk("t1_m1_ack", 32'(m1_ack_o), 32'h0);
        step(); mrd[0] = 1'b0; ack_i = 1'b0; data_i = 32'h0;
        @(negedge clk); chk("t1_after_grant", 32'(grant), 32'h0);

        // m1 write 0x20 to 0x2004 with no ack: timeout
        step(); mwe[1] = 1'b1; maddr[1] = 32'h2004; mdata[1] = 32'h20;
        @(negedge clk);
        for (int i = 1; i <= TMO; i++) begin
            step();
            @(negedge clk);
            chk("t3_we_hold", 32'(we_o), 32'h1);
            chk("t3_grant", 32'(grant), 32'h2);
        end
        step();
        @(negedge clk);
        chk("t3_we_drop", 32'(we_o), 32'h0);
        chk("t3_m1_ack", 32'(m1_ack_o), 32'h1);
        chk("t3_m1_data", m1_data_o, 32'hFFFF_FFFF);
        chk("t3_no_err_yet", 32'(bus_err), 32'h0);
        step(); mwe[1] = 1'b0;
        @(negedge clk);
        chk("t3_bus_err", 32'(bus_err), 32'h1);
        chk("t3_err_addr", bus_err_addr, 32'h2004);

        // m0 read acked exactly in the timeout cycle
        step(); mrd[0] = 1'b1; maddr[0] = 32'h3000;
        @(negedge clk);
        chk("t4_err_pulse_end", 32'(bus_err), 32'h0);
        for (int i = 1; i <= TMO; i++) begin
            step();
            @(negedge clk); chk("t4_no_ack", 32'(m0_ack_o), 32'h0);
        end
        step(); ack_i = 1'b1; data_i = 32'h1234_5678;
        @(negedge clk);
        chk("t4_m0_ack", 32'(m0_ack_o), 32'h1);
        chk("t4_m0_data", m0_data_o, 32'h1234_5678);
        chk("t4_rd_kept", 32'(rd_o), 32'h1);
        step(); mrd[0] = 1'b0; ack_i = 1'b0; data_i = 32'h0;
        @(negedge clk); chk("t4_no_err", 32'(bus_err), 32'h0);
        step();
        @(negedge clk);
        chk("t4_no_err2", 32'(bus_err), 32'h0);
        chk("t4_err_addr_held", bus_err_addr, 32'h2004);

        // m0 aborts while m1 waits
        step(); mrd[0] = 1'b1; maddr[0] = 32'h4000;
        @(negedge clk);
        step(); mrd[1] = 1'b1; maddr[1] = 32'h5000;
        @(negedge clk); chk("t5_grant0", 32'(grant), 32'h1);
        step(); mrd[0] = 1'b0;
        @(negedge clk); chk("t5_abort_no_ack", 32'(m0_ack_o), 32'h0);
        step();
        @(negedge clk);
        chk("t5_idle", 32'(grant), 32'h0);
        chk("t5_no_err", 32'(bus_err), 32'h0);
        step();
        @(negedge clk);
        chk("t5_grant1", 32'(grant), 32'h2);
        chk("t5_addr1", addr_o, 32'h5000);

        // reset during BUS1, then tie goes to m0
        step(); rst = 1'b1;
        @(negedge clk);
        step(); rst = 1'b0; mrd[0] = 1'b1; maddr[0] = 32'h6000;
        @(negedge clk);
        chk("t6_grant", 32'(grant), 32'h0);
        chk("t6_rd_o", 32'(rd_o), 32'h0);
        chk("t6_m1_ack", 32'(m1_ack_o), 32'h0);
        step(); ack_i = 1'b1;
        @(negedge clk);
        chk("t6_tie_m0", 32'(grant), 32'h1);
        chk("t6_addr", addr_o, 32'h6000);
        step(); mrd[0] = 1'b0; mrd[1] = 1'b0; ack_i = 1'b0;

        // round robin with both masters requesting continuously
        step(); rst = 1'b1;
        step(); rst = 1'b0; mrd[0] = 1'b1; mrd[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i != 0) step();
            ack_i = (i % 3 == 2);
            @(negedge clk);
            chk("rr_grant", 32'(grant), 32'(rr_exp[i]));
        end
        step(); mrd[0] = 1'b0; mrd[1] = 1'b0; ack_i = 1'b0;

        // random traffic
        repeat (3000) begin
            step();
            rst = ($urandom_range(0, 299) == 0);
            for (int m = 0; m < 2; m++) begin
                if (seen_ack[m]) begin
                    if ($urandom_range(0, 1) == 1) new_req(m);
                    else begin mrd[m] = 1'b0; mwe[m] = 1'b0; end
                end else if (mrd[m] | mwe[m]) begin
                    if ($urandom_range(0, 99) < 3) begin mrd[m] = 1'b0; mwe[m] = 1'b0; end
                end else if ($urandom_range(0, 99) < 30) begin
                    new_req(m);
                end
            end
            ack_i  = ($urandom_range(0, 99) < 30);
            data_i = $urandom;
        end
        step(); rst = 1'b0; ack_i = 1'b0;
        for (int m = 0; m < 2; m++) begin mrd[m] = 1'b0; mwe[m] = 1'b0; end
        repeat (3) step();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
